// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction
// memory and registers the returned instruction into a valid/ready IF/ID slot.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 8
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module fetch_unit #(
  parameter int                PC_WIDTH   = 32,
  parameter int                addr_width = `MEM_ADDR_WIDTH,
  parameter int                word_width = `WORD_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  output logic [addr_width-1:0] imem_addr,
  input  logic [word_width-1:0] imem_inst,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [word_width-1:0] out_inst,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic                  fetch_fault,
  output logic [PC_WIDTH-1:0]   fault_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t state, next_state;

  logic [PC_WIDTH-1:0] pc;
  logic accept;
  logic misaligned;
  logic do_capture, do_redirect, do_fault, do_drain;

  assign imem_addr  = pc[addr_width+1:2];
  assign accept     = !out_valid || out_ready;
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Redirects outrank capture; a misaligned target parks the stage in FAULT.
  always_comb begin
    next_state  = state;
    do_capture  = 1'b0;
    do_redirect = 1'b0;
    do_fault    = 1'b0;
    do_drain    = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_valid && misaligned) begin
          do_fault   = 1'b1;
          next_state = FAULT;
        end else begin
          if (redirect_valid) do_redirect = 1'b1;
          else                do_drain    = out_ready;
          if (fetch_en) next_state = RUN;
        end
      end
      RUN: begin
        if (redirect_valid && misaligned) begin
          do_fault   = 1'b1;
          next_state = FAULT;
        end else if (redirect_valid) begin
          do_redirect = 1'b1;
          if (!fetch_en) next_state = IDLE;
        end else if (!fetch_en) begin
          do_drain   = out_ready;
          next_state = IDLE;
        end else if (accept) begin
          do_capture = 1'b1;
        end
      end
      FAULT: next_state = FAULT;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      out_valid   <= 1'b0;
      out_inst    <= '0;
      out_pc      <= '0;
      fetch_fault <= 1'b0;
      fault_pc    <= '0;
    end else if (do_fault) begin
      fetch_fault <= 1'b1;
      fault_pc    <= redirect_pc;
      out_valid   <= 1'b0;
    end else if (do_redirect) begin
      pc        <= redirect_pc;
      out_valid <= 1'b0;
    end else if (do_capture) begin
      out_inst  <= imem_inst;
      out_pc    <= pc;
      out_valid <= 1'b1;
      pc        <= pc + PC_WIDTH'(4);
    end else if (do_drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule
